tone_arbiter: RTL and testbench

- Shares the board's single square-wave tone output between the background song sequencer and up to `N_SFX` sound-effect requesters.
- Sound effects pre-empt the music. Between effects, arbitration is fixed-priority and non-preemptive.
- Each effect plays for a programmed number of duration ticks.
- The block contains its own tick prescaler and half-period divider, and drives the speaker pin directly.

---
 rtl/tone_arbiter.sv | 167 ++++++++++++++++
 tb/tb_tone_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tone_arbiter.sv
// Shares one square-wave speaker pin between the music sequencer and N_SFX effect requesters.
// Grant, owner and active half-period are registered (1 cycle); sound toggles half cycles after its half loads.
// No backpressure: sfx_req levels are held by requesters until sfx_ack; optional GAP state via `TONE_ARB_GAP_EN.
module tone_arbiter #(
    parameter int N_SFX    = 3,
    parameter int TICK_DIV = 3_125_000,
    parameter int HALF_W   = 22,
    parameter int DUR_W    = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [HALF_W-1:0]       music_half,
    input  logic                    music_valid,
    input  logic [N_SFX-1:0]        sfx_req,
    input  logic [N_SFX*HALF_W-1:0] sfx_half,
    input  logic [N_SFX*DUR_W-1:0]  sfx_ticks,
    output logic [N_SFX-1:0]        sfx_ack,
    output logic [N_SFX-1:0]        sfx_done,
    output logic [1:0]              owner,
    output logic                    sound
);

    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int IDX_W = (N_SFX > 1) ? $clog2(N_SFX) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_MUSIC = 2'd1;
    localparam logic [1:0] ST_SFX   = 2'd2;
`ifdef TONE_ARB_GAP_EN
    localparam logic [1:0] ST_GAP   = 2'd3;
`endif

    logic [1:0]        state, state_d;
    logic [PRE_W-1:0]  pre_cnt;
    logic [DUR_W-1:0]  dur_cnt, dur_d;
    logic [HALF_W-1:0] lat_half, lat_half_d;
    logic [IDX_W-1:0]  lat_idx, lat_idx_d;
    logic [HALF_W-1:0] act_half, act_half_d;
    logic [HALF_W-1:0] div_cnt;
    logic [N_SFX-1:0]  ack_d, done_d;
    logic [DUR_W-1:0]  win_ticks;
    logic [IDX_W-1:0]  win_idx;
    logic              grant, tick, arb;

    // Lowest requesting index wins.
    always_comb begin
        grant   = 1'b0;
        win_idx = '0;
        for (int i = 0; i < N_SFX; i++) begin
            if (sfx_req[i] && !grant) begin
                grant   = 1'b1;
                win_idx = IDX_W'(i);
            end
        end
    end

    assign tick      = (pre_cnt == PRE_W'(TICK_DIV - 1));
    assign arb       = (state == ST_IDLE) || (state == ST_MUSIC);
    assign win_ticks = sfx_ticks[int'(win_idx)*DUR_W +: DUR_W];

    always_comb begin
        state_d    = state;
        lat_half_d = lat_half;
        lat_idx_d  = lat_idx;
        dur_d      = dur_cnt;
        ack_d      = '0;
        done_d     = '0;
        case (state)
            ST_IDLE, ST_MUSIC: begin
                if (grant) begin
                    state_d        = ST_SFX;
                    lat_half_d     = sfx_half[int'(win_idx)*HALF_W +: HALF_W];
                    lat_idx_d      = win_idx;
                    dur_d          = (win_ticks == '0) ? DUR_W'(1) : win_ticks;
                    ack_d[win_idx] = 1'b1;
                end else begin
                    state_d = music_valid ? ST_MUSIC : ST_IDLE;
                end
            end
            ST_SFX: begin
                if (tick) begin
                    if (dur_cnt <= DUR_W'(1)) begin
                        done_d[lat_idx] = 1'b1;
                        dur_d           = '0;
`ifdef TONE_ARB_GAP_EN
                        state_d         = ST_GAP;
`else
                        state_d         = music_valid ? ST_MUSIC : ST_IDLE;
`endif
                    end else begin
                        dur_d = dur_cnt - DUR_W'(1);
                    end
                end
            end
`ifdef TONE_ARB_GAP_EN
            ST_GAP: begin
                if (tick) begin
                    state_d = music_valid ? ST_MUSIC : ST_IDLE;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // Half-period tracks the state being entered so it lands in the same cycle as owner.
    always_comb begin
        act_half_d = '0;
        if (state_d == ST_SFX) begin
            act_half_d = lat_half_d;
        end else if (state_d == ST_MUSIC) begin
            act_half_d = music_half;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            pre_cnt  <= '0;
            dur_cnt  <= '0;
            lat_half <= '0;
            lat_idx  <= '0;
            sfx_ack  <= '0;
            sfx_done <= '0;
        end else begin
            state    <= state_d;
            dur_cnt  <= dur_d;
            lat_half <= lat_half_d;
            lat_idx  <= lat_idx_d;
            sfx_ack  <= ack_d;
            sfx_done <= done_d;
            if ((arb && grant) || tick) begin
                pre_cnt <= '0;
            end else begin
                pre_cnt <= pre_cnt + PRE_W'(1);
            end
        end
    end

    // A new half value restarts the count but keeps the current level, so no runt pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            act_half <= '0;
            div_cnt  <= '0;
            sound    <= 1'b0;
        end else begin
            act_half <= act_half_d;
            if (act_half_d != act_half) begin
                div_cnt <= '0;
                if (act_half_d == '0) begin
                    sound <= 1'b0;
                end
            end else if (act_half == '0) begin
                div_cnt <= '0;
                sound   <= 1'b0;
            end else if (div_cnt == act_half - HALF_W'(1)) begin
                div_cnt <= '0;
                sound   <= ~sound;
            end else begin
                div_cnt <= div_cnt + HALF_W'(1);
            end
        end
    end

    assign owner = state;

endmodule

// File: tb/tb_tone_arbiter.sv
// Directed bench for tone_arbiter with TICK_DIV=4; GAP expectations follow `TONE_ARB_GAP_EN.
module tb_tone_arbiter;

    localparam int N  = 3;
    localparam int HW = 22;
    localparam int DW = 8;
`ifdef TONE_ARB_GAP_EN
    localparam int GAP_CYC = 4;
`else
    localparam int GAP_CYC = 0;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic [HW-1:0]   music_half;
    logic            music_valid;
    logic [N-1:0]    sfx_req;
    logic [N*HW-1:0] sfx_half;
    logic [N*DW-1:0] sfx_ticks;
    logic [N-1:0]    sfx_ack;
    logic [N-1:0]    sfx_done;
    logic [1:0]      owner;
    logic            sound;

    int total = 0;
    int bad   = 0;

    tone_arbiter #(.N_SFX(N), .TICK_DIV(4), .HALF_W(HW), .DUR_W(DW)) dut (
        .clk(clk), .rst_n(rst_n), .music_half(music_half), .music_valid(music_valid),
        .sfx_req(sfx_req), .sfx_half(sfx_half), .sfx_ticks(sfx_ticks),
        .sfx_ack(sfx_ack), .sfx_done(sfx_done), .owner(owner), .sound(sound)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_sfx(input int i, input int half, input int ticks);
        sfx_half[i*HW +: HW]  = HW'(half);
        sfx_ticks[i*DW +: DW] = DW'(ticks);
    endtask

    task automatic wait_done(input string tag, input logic [N-1:0] exp, input int exp_cyc);
        int n = 0;
        do begin
            step();
            n++;
        end while (sfx_done == '0 && n < 200);
        chk({tag, "_done"}, 32'(sfx_done), 32'(exp));
        chk({tag, "_cyc"}, n, exp_cyc);
    endtask

    task automatic wait_ack(input string tag, input logic [N-1:0] exp, input int exp_cyc);
        int n = 0;
        do begin
            step();
            n++;
        end while (sfx_ack == '0 && n < 200);
        chk({tag, "_ack"}, 32'(sfx_ack), 32'(exp));
        chk({tag, "_cyc"}, n, exp_cyc);
    endtask

    task automatic wait_owner(input string tag, input logic [1:0] exp);
        int n = 0;
        while (owner != exp && n < 100) begin
            step();
            n++;
        end
        chk(tag, 32'(owner), 32'(exp));
    endtask

    task automatic toggle_gap(output int n);
        logic prev;
        prev = sound;
        n = 0;
        do begin
            step();
            n++;
        end while (sound == prev && n < 100);
    endtask

    initial begin
        int g, n, tog;
        logic prev, hi;
        int pulses;

        rst_n       = 1'b0;
        music_half  = '0;
        music_valid = 1'b0;
        sfx_req     = 3'b111;
        sfx_half    = '0;
        sfx_ticks   = '0;
        set_sfx(0, 1, 1);

        // Reset holds everything quiet despite pending requests.
        repeat (3) step();
        chk("rst_owner", 32'(owner), 0);
        chk("rst_sound", 32'(sound), 0);
        chk("rst_ack", 32'(sfx_ack), 0);
        rst_n = 1'b1;
        step();
        chk("rel_ack", 32'(sfx_ack), 32'(3'b001));
        chk("rel_owner", 32'(owner), 2);
        sfx_req = '0;
        wait_done("rel", 3'b001, 4);
        wait_owner("rel_idle", 2'd0);

        // Music only.
        music_valid = 1'b1;
        music_half  = 5;
        step();
        chk("mus_owner", 32'(owner), 1);
        toggle_gap(g);
        toggle_gap(g);
        chk("mus_gap5a", g, 5);
        toggle_gap(g);
        chk("mus_gap5b", g, 5);
        music_half = 3;
        toggle_gap(g);
        toggle_gap(g);
        chk("mus_gap3a", g, 3);
        toggle_gap(g);
        chk("mus_gap3b", g, 3);

        // Pre-emption, with a music change in the same cycle as the request.
        set_sfx(1, 2, 3);
        sfx_req    = 3'b010;
        music_half = 7;
        step();
        chk("pre_ack", 32'(sfx_ack), 32'(3'b010));
        chk("pre_owner", 32'(owner), 2);
        sfx_req = '0;
        n = 0;
        tog = 0;
        prev = sound;
        while (n < 200) begin
            step();
            n++;
            if (sfx_done != '0) break;
            if (sound != prev) tog++;
            prev = sound;
        end
        chk("pre_done", 32'(sfx_done), 32'(3'b010));
        chk("pre_len", n, 12);
        chk("pre_toggles", tog, 5);
`ifdef TONE_ARB_GAP_EN
        chk("gap_owner", 32'(owner), 3);
        chk("gap_sound", 32'(sound), 0);
        n = 0;
        hi = 1'b0;
        while (owner == 2'd3 && n < 100) begin
            hi |= sound;
            step();
            n++;
        end
        chk("gap_len", n, 4);
        chk("gap_silent", 32'(hi), 0);
`endif
        chk("resume_owner", 32'(owner), 1);
        toggle_gap(g);
        chk("resume_gap7", g, 7);

        // Priority and non-preemption between effects.
        music_valid = 1'b0;
        wait_owner("pri_idle", 2'd0);
        set_sfx(0, 1, 1);
        set_sfx(1, 1, 2);
        set_sfx(2, 1, 1);
        sfx_req = 3'b110;
        step();
        chk("pri_ack1", 32'(sfx_ack), 32'(3'b010));
        sfx_req = 3'b100;
        step();
        step();
        sfx_req = 3'b101;
        wait_done("pri_d1", 3'b010, 6);
        wait_ack("pri_a0", 3'b001, GAP_CYC + 1);
        sfx_req = 3'b100;
        wait_done("pri_d0", 3'b001, 4);
        wait_ack("pri_a2", 3'b100, GAP_CYC + 1);
        sfx_req = '0;
        wait_done("pri_d2", 3'b100, 4);

        // Edge values: zero ticks, zero half.
        wait_owner("edge_idle", 2'd0);
        set_sfx(0, 1, 0);
        sfx_req = 3'b001;
        step();
        chk("t0_ack", 32'(sfx_ack), 32'(3'b001));
        sfx_req = '0;
        wait_done("t0", 3'b001, 4);
        wait_owner("h0_idle", 2'd0);
        set_sfx(2, 0, 2);
        sfx_req = 3'b100;
        step();
        chk("h0_ack", 32'(sfx_ack), 32'(3'b100));
        sfx_req = '0;
        n = 0;
        hi = sound;
        while (n < 200) begin
            step();
            n++;
            hi |= sound;
            if (sfx_done != '0) break;
        end
        chk("h0_done", 32'(sfx_done), 32'(3'b100));
        chk("h0_len", n, 8);
        chk("h0_silent", 32'(hi), 0);

        // Reset in the middle of an effect.
        wait_owner("mr_idle", 2'd0);
        set_sfx(1, 2, 3);
        sfx_req = 3'b010;
        step();
        chk("mr_ack", 32'(sfx_ack), 32'(3'b010));
        sfx_req = '0;
        repeat (4) step();
        rst_n = 1'b0;
        step();
        chk("mr_owner", 32'(owner), 0);
        chk("mr_sound", 32'(sound), 0);
        chk("mr_outs", 32'({sfx_ack, sfx_done}), 0);
        rst_n = 1'b1;
        pulses = 0;
        repeat (20) begin
            step();
            if (sfx_done != '0) pulses++;
        end
        chk("mr_no_done", pulses, 0);
        chk("mr_owner_after", 32'(owner), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
